// File: rtl/config_readback_fsm.sv
// config_readback_fsm
//   Readback engine for the configuration column array. On a start request it
//   reads the array one column at a time, captures that column's Dim rows and
//   streams them out over a valid/ready word interface, row Dim-1 first, in
//   the same order the loader consumed them. The stream can therefore be
//   replayed into the loader unchanged.
//
// Ports
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   start_i      readback request, honoured only in IDLE and DONE
//   col_rd_en_o  one-hot column read enable (high for one cycle per column)
//   col_data_i   rows of the selected column, valid the cycle after the enable
//   bit_o        readback word
//   bit_v_o      bit_o valid
//   bit_r_i      consumer ready
//   busy_o       high from the SEL cycle through the last transfer
//   done_o       all columns streamed; held until the next start
module config_readback_fsm #(
  parameter int Dim   = 4,
  parameter int Width = 77
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        start_i,
  output logic [Dim-1:0]              col_rd_en_o,
  input  logic [Dim-1:0][Width-1:0]   col_data_i,
  output logic [Width-1:0]            bit_o,
  output logic                        bit_v_o,
  input  logic                        bit_r_i,
  output logic                        busy_o,
  output logic                        done_o
);

  localparam int ColW = (Dim > 1) ? $clog2(Dim) : 1;
  localparam int CntW = $clog2(Dim + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEL  = 3'd1,
    CAP  = 3'd2,
    SEND = 3'd3,
    DONE = 3'd4
  } state_e;

  state_e                     state_q, state_d;
  logic [ColW-1:0]            col_q, col_d;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic [Dim-1:0][Width-1:0]  buf_q, buf_d;

  // Outputs are flops loaded from the next-state decode, so none of them has
  // a combinational path from start_i or bit_r_i, and the async reset forces
  // them low immediately.
  logic [Dim-1:0]             col_rd_en_q, col_rd_en_d;
  logic                       bit_v_q, bit_v_d;
  logic                       busy_q, busy_d;
  logic                       done_q, done_d;

  logic                       fire;

  // bit_v_q is exactly (state_q == SEND), so this is the accepted transfer.
  assign fire = bit_v_q & bit_r_i;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;

    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d = SEL;
          col_d   = '0;
        end
      end
      SEL: begin
        state_d = CAP;
      end
      CAP: begin
        buf_d   = col_data_i;
        cnt_d   = CntW'(Dim);
        state_d = SEND;
      end
      SEND: begin
        if (fire) begin
          // Top row leaves first; everything moves up one slot.
          for (int r = Dim - 1; r > 0; r--) begin
            buf_d[r] = buf_q[r-1];
          end
          buf_d[0] = '0;
          cnt_d    = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            if (col_q == ColW'(Dim - 1)) begin
              state_d = DONE;
            end else begin
              col_d   = col_q + ColW'(1);
              state_d = SEL;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    col_rd_en_d = '0;
    if (state_d == SEL) begin
      col_rd_en_d[col_d] = 1'b1;
    end
    bit_v_d = (state_d == SEND);
    busy_d  = (state_d == SEL) || (state_d == CAP) || (state_d == SEND);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      col_q       <= '0;
      cnt_q       <= '0;
      buf_q       <= '0;
      col_rd_en_q <= '0;
      bit_v_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      col_rd_en_q <= col_rd_en_d;
      bit_v_q     <= bit_v_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign col_rd_en_o = col_rd_en_q;
  assign bit_o       = buf_q[Dim-1];
  assign bit_v_o     = bit_v_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: doc/config_readback_fsm.md
# config_readback_fsm

Readback engine for the configuration column array: the mirror of the global load FSM. On a start request it reads the array one column at a time, captures the column's `Dim` rows of `Width` bits, and streams them out over a valid/ready word interface in load order. It sits between the column array's read port and the host-side readback consumer.

## Interface
- `Dim`, default 4: columns in the array, which is also rows per column.
- `Width`, default 77: bits per row word.

- `clk_i` input 1: clock; all state changes on the rising edge.
- `rst_ni` input 1: reset, asynchronous and active-low.
- `start_i` input 1: readback request; sampled only in IDLE and DONE.
- `col_rd_en_o` output Dim: one-hot column read enable.
- `col_data_i` input [Dim-1:0][Width-1:0]: rows of the selected column; valid in the cycle after `col_rd_en_o`.
- `bit_o` output Width: readback word.
- `bit_v_o` output 1: `bit_o` is valid.
- `bit_r_i` input 1: consumer ready.
- `busy_o` output 1: high in every state except IDLE and DONE.
- `done_o` output 1: all columns have been streamed.

## Operation
- State machine: IDLE, SEL, CAP, SEND, DONE.
- IDLE
  - `start_i` moves to SEL and sets `col` to 0.
  - Otherwise stays in IDLE.
- SEL, one cycle
  - `col_rd_en_o[col]` = 1; all other bits are 0.
  - Next state is CAP.
- CAP, one cycle
  - `buf[r] <= col_data_i[r]` for all r.
  - `cnt <= Dim`.
  - Next state is SEND.
- SEND
  - `bit_v_o` = 1 and `bit_o` = `buf[Dim-1]`.
  - On `bit_v_o & bit_r_i`: shift `buf[r] <= buf[r-1]` for r = Dim-1..1, clear `buf[0]`, and set `cnt <= cnt-1`.
  - If `cnt` = 1 and the transfer fires: go to DONE when `col` = Dim-1; otherwise `col <= col+1` and go to SEL.
- Word order: row Dim-1 first, down to row 0. This is the order the loader received the words, so a readback stream can be replayed into the loader unchanged.
- DONE
  - `done_o` = 1 and is held.
  - `start_i` clears `done_o`, sets `col` to 0 and goes to SEL.
- `start_i` outside IDLE and DONE is ignored.
- Widths: `col` is `$clog2(Dim)` bits, `cnt` is `$clog2(Dim+1)` bits. Neither wraps; transitions occur before any wrap.
- `bit_o`, `bit_v_o`, `col_rd_en_o` and `done_o` are decoded only from registered state and registered `buf`. None of them has a combinational path from `bit_r_i` or `start_i`.

## Timing
- Reset values: all outputs 0, state IDLE, `buf` all-zero, `col` 0, `cnt` 0.
- Reset mid-operation (`rst_ni` low in any state):
  - Outputs go to 0 immediately and asynchronously.
  - No further word is presented.
  - After release, the block restarts only on a new `start_i`.
- Latency with `start_i` in cycle 0:
  - `col_rd_en_o` is high in cycle 1.
  - Capture happens in cycle 2.
  - The first `bit_v_o` is in cycle 3.
- Handshake:
  - A word transfers in a cycle where `bit_v_o & bit_r_i` = 1.
  - While `bit_r_i` = 0, `bit_v_o` stays 1 and `bit_o` holds stable.
- Throughput with `bit_r_i` tied high:
  - Dim words per column, plus 2 cycles (SEL, CAP) of overhead per column.
  - Full readback is Dim·(Dim+2) cycles, which is 24 at Dim = 4.
  - `done_o` rises the cycle after the last transfer.
- `bit_v_o` is 0 in SEL, CAP, IDLE and DONE.
- `busy_o` is asserted from the SEL cycle through the cycle of the last transfer.

## Test plan
- Basic readback:
  - Setup: reset, then drive `start_i` for one cycle. The column model returns `{c,r}` encoded in the low byte of row r of column c. `bit_r_i` = 1.
  - Required: 16 words in the order c0r3, c0r2, c0r1, c0r0, c1r3 … c3r0.
  - Required: `done_o` = 1 at cycle 25.
  - Required: `col_rd_en_o` runs 0001, 0010, 0100, 1000, one cycle each.
- Backpressure:
  - Setup: hold `bit_r_i` = 0 for 5 cycles on word 2 of column 1.
  - Required: `bit_v_o` stays 1 and `bit_o` stays stable for those 5 cycles.
  - Required: no word is dropped or duplicated.
  - Required: `done_o` is delayed by exactly 5 cycles.
- Random ready:
  - Setup: `bit_r_i` driven at 30% duty cycle.
  - Required: the sequence of accepted words is identical to the basic readback.
- Start while busy:
  - Setup: pulse `start_i` during SEND of column 2.
  - Required: no effect; the sequence is unchanged.
  - Setup: pulse `start_i` in DONE.
  - Required: `done_o` falls and a second full 16-word readback follows.
- Async reset mid-stream:
  - Setup: drop `rst_ni` during CAP of column 1, between clock edges.
  - Required: `bit_v_o`, `col_rd_en_o` and `busy_o` go to 0 before the next edge.
  - Setup: release reset, then `start_i`.
  - Required: readback begins again at column 0.
- Loopback:
  - Setup: feed `bit_o`/`bit_v_o`/`bit_r_i` into the load FSM.
  - Required: the reloaded array equals the source array.
